auction_bid_collector: RTL and testbench

AUCTION_BID_COLLECTOR -- requirements
Module: auction_bid_collector

---
 rtl/auction_bid_collector_if.sv | 29 ++
 rtl/auction_bid_collector.sv | 99 +++++++++
 tb/tb_auction_bid_collector.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/auction_bid_collector_if.sv
// Bundle of the submission, sealing and sealed-vector signals of the
// auction bid collector. The master side is the bidder/downstream
// environment; the slave side is the collector itself.
interface auction_bid_collector_if #(
    parameter int N = 3,
    parameter int W = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          in_id;
    logic [W-1:0]          in_bid;
    logic                  close;
    logic                  out_valid;
    logic                  out_ready;
    logic [(2**N)*W-1:0]   bid;
    logic [2**N-1:0]       bid_mask;
    logic [N:0]            bid_count;
    logic                  dup_err;

    modport master (
        output in_valid, in_id, in_bid, close, out_ready,
        input  in_ready, out_valid, bid, bid_mask, bid_count, dup_err
    );

    modport slave (
        input  in_valid, in_id, in_bid, close, out_ready,
        output in_ready, out_valid, bid, bid_mask, bid_count, dup_err
    );
endinterface

// File: rtl/auction_bid_collector.sv
// Auction bid collector: gathers one bid per bidder slot, flags repeat
// submissions, and seals the packed bid vector when every slot is filled
// or when the auction is closed early. The sealed vector is held until
// the downstream auction stage consumes it, then all slots are cleared.
module auction_bid_collector #(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    auction_bid_collector_if.slave  bus
);
    localparam int SLOTS = 2**N;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t               state_q;
    logic [SLOTS*W-1:0]   bid_q;
    logic [SLOTS-1:0]     mask_q;
    logic [N:0]           count_q;
    logic                 dup_q;

    logic                 accept;
    logic                 slot_taken;
    logic                 fills_last;
    logic [SLOTS*W-1:0]   bid_d;
    logic [SLOTS-1:0]     mask_d;
    logic [N:0]           count_d;

    // Work out whether this edge accepts a submission and what the slot
    // storage looks like afterwards.
    always_comb begin
        // NOTE: every signal gets a default before the conditional updates,
        // so no path leaves it unassigned and no latch is inferred.
        bid_d      = bid_q;
        mask_d     = mask_q;
        count_d    = count_q;
        accept     = bus.in_valid && (state_q == COLLECT);
        slot_taken = mask_q[bus.in_id];
        fills_last = 1'b0;
        if (accept && !slot_taken) begin
            bid_d[int'(bus.in_id)*W +: W] = bus.in_bid;
            mask_d[bus.in_id]             = 1'b1;
            count_d                       = count_q + (N+1)'(1);
            fills_last                    = (count_q == (N+1)'(SLOTS-1));
        end
    end

    // Collection / hold state machine with all slot state registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            // NOTE: the slot storage is cleared on reset because an
            // unfilled slot must read as zero in the sealed vector.
            state_q <= COLLECT;
            bid_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    // A submission on the closing edge is stored before sealing.
                    bid_q   <= bid_d;
                    mask_q  <= mask_d;
                    count_q <= count_d;
                    dup_q   <= accept && slot_taken;
                    if (bus.close || fills_last) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    dup_q <= 1'b0;
                    if (bus.out_ready) begin
                        state_q <= COLLECT;
                        bid_q   <= '0;
                        mask_q  <= '0;
                        count_q <= '0;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.bid       = bid_q;
    assign bus.bid_mask  = mask_q;
    assign bus.bid_count = count_q;
    assign bus.dup_err   = dup_q;

endmodule

// File: tb/tb_auction_bid_collector.sv
// Self-checking bench for auction_bid_collector (N=3, W=3). A small
// reference model tracks slot contents; each sealing stimulus pushes the
// expected sealed vector into a scoreboard queue that is popped when the
// collector raises out_valid.
module tb_auction_bid_collector;
    localparam int N = 3;
    localparam int W = 3;
    localparam int SLOTS = 2**N;

    typedef struct packed {
        logic [SLOTS*W-1:0] bid;
        logic [SLOTS-1:0]   mask;
        logic [N:0]         count;
    } seal_t;

    logic clk;
    logic rst;

    auction_bid_collector_if #(.N(N), .W(W)) bus ();

    auction_bid_collector #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [SLOTS*W-1:0] mdl_bid;
    logic [SLOTS-1:0]   mdl_mask;
    logic [N:0]         mdl_count;
    seal_t              sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        mdl_bid   = '0;
        mdl_mask  = '0;
        mdl_count = '0;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_id     = '0;
        bus.in_bid    = '0;
        bus.close     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_clear();
        sb_q.delete();
    endtask

    // Drive one submission (optionally with close) for a single edge and
    // update the model; pushes an expected seal when this edge seals.
    task automatic submit(input logic [N-1:0] id, input logic [W-1:0] b,
                          input logic cl, output logic exp_dup);
        seal_t s;
        bus.in_valid = 1'b1;
        bus.in_id    = id;
        bus.in_bid   = b;
        bus.close    = cl;
        exp_dup = mdl_mask[id];
        if (!mdl_mask[id]) begin
            mdl_bid[int'(id)*W +: W] = b;
            mdl_mask[id]             = 1'b1;
            mdl_count                = mdl_count + 1'b1;
        end
        if (cl || mdl_count == (N+1)'(SLOTS)) begin
            s.bid = mdl_bid; s.mask = mdl_mask; s.count = mdl_count;
            sb_q.push_back(s);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.close    = 1'b0;
    endtask

    task automatic seal_close();
        seal_t s;
        bus.close = 1'b1;
        s.bid = mdl_bid; s.mask = mdl_mask; s.count = mdl_count;
        sb_q.push_back(s);
        tick();
        bus.close = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then pop and compare the sealed vector.
    task automatic test_seal_output(input string tag);
        seal_t exp;
        int    waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s seal_timeout: out_valid=%b required 1 within 10 cycles", tag, bus.out_valid);
        end else if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_seal: out_valid=1 but no seal expected", tag);
        end else begin
            exp = sb_q.pop_front();
            if (bus.bid !== exp.bid) begin
                n_fail++;
                $display("FAIL %s seal_bid: got %h required %h", tag, bus.bid, exp.bid);
            end
            n_checks++;
            if (bus.bid_mask !== exp.mask) begin
                n_fail++;
                $display("FAIL %s seal_mask: got %b required %b", tag, bus.bid_mask, exp.mask);
            end
            n_checks++;
            if (bus.bid_count !== exp.count) begin
                n_fail++;
                $display("FAIL %s seal_count: got %0d required %0d", tag, bus.bid_count, exp.count);
            end
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s seal_in_ready: got %b required 0", tag, bus.in_ready);
            end
        end
    endtask

    // One-cycle consume, then expect an empty collector ready for bids.
    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        mdl_clear();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s consume_handshake: out_valid=%b in_ready=%b required 0/1", tag, bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.bid !== '0 || bus.bid_mask !== '0 || bus.bid_count !== '0) begin
            n_fail++;
            $display("FAIL %s consume_clear: bid=%h mask=%b count=%0d required all 0", tag, bus.bid, bus.bid_mask, bus.bid_count);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_id     = 3'd5;
        bus.in_bid    = 3'd7;
        bus.close     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        idle_inputs();
        rst = 1'b0;
        mdl_clear();
        sb_q.delete();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        n_checks++;
        if (bus.bid !== '0 || bus.bid_mask !== '0 || bus.bid_count !== '0 || bus.dup_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: bid=%h mask=%b count=%0d dup=%b required all 0", bus.bid, bus.bid_mask, bus.bid_count, bus.dup_err);
        end
    endtask

    task automatic test_full_fill();
        logic [W-1:0] bids [SLOTS] = '{3'd6, 3'd0, 3'd1, 3'd4, 3'd7, 3'd3, 3'd5, 3'd2};
        logic         d;
        for (int i = 0; i < SLOTS; i++) begin
            submit(N'(i), bids[i], 1'b0, d);
            if (i == 0) begin
                n_checks++;
                if (bus.bid_count !== 4'd1 || bus.bid_mask !== 8'h01) begin
                    n_fail++;
                    $display("FAIL fill_first_accept: count=%0d mask=%b required 1/00000001", bus.bid_count, bus.bid_mask);
                end
            end
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.bid_count !== 4'd8 || bus.bid_mask !== 8'hFF) begin
            n_fail++;
            $display("FAIL fill_latency: out_valid=%b count=%0d mask=%h required 1/8/ff", bus.out_valid, bus.bid_count, bus.bid_mask);
        end
        n_checks++;
        if (bus.bid !== 24'b010_101_011_111_100_001_000_110) begin
            n_fail++;
            $display("FAIL fill_bid_vector: got %h required %h", bus.bid, 24'b010_101_011_111_100_001_000_110);
        end
        test_seal_output("full_fill");
        consume("full_fill");
    endtask

    task automatic test_duplicate();
        logic d;
        submit(3'd2, 3'd1, 1'b0, d);
        n_checks++;
        if (bus.dup_err !== 1'b0 || bus.bid_count !== 4'd1) begin
            n_fail++;
            $display("FAIL dup_first: dup_err=%b count=%0d required 0/1", bus.dup_err, bus.bid_count);
        end
        submit(3'd2, 3'd7, 1'b0, d);
        n_checks++;
        if (bus.dup_err !== d) begin
            n_fail++;
            $display("FAIL dup_pulse: dup_err=%b required %b", bus.dup_err, d);
        end
        n_checks++;
        if (bus.bid[2*W +: W] !== 3'd1 || bus.bid_count !== 4'd1) begin
            n_fail++;
            $display("FAIL dup_unchanged: slot2=%0d count=%0d required 1/1", bus.bid[2*W +: W], bus.bid_count);
        end
        tick();
        n_checks++;
        if (bus.dup_err !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_one_cycle: dup_err=%b required 0", bus.dup_err);
        end
        seal_close();
        test_seal_output("duplicate");
        consume("duplicate");
    endtask

    task automatic test_early_close();
        logic d;
        submit(3'd0, 3'd7, 1'b0, d);
        submit(3'd4, 3'd6, 1'b0, d);
        submit(3'd3, 3'd7, 1'b1, d);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.bid_mask !== 8'b00011001 || bus.bid_count !== 4'd3) begin
            n_fail++;
            $display("FAIL close_accept: out_valid=%b mask=%b count=%0d required 1/00011001/3", bus.out_valid, bus.bid_mask, bus.bid_count);
        end
        test_seal_output("early_close");
        consume("early_close");
    endtask

    task automatic test_backpressure();
        logic d;
        submit(3'd1, 3'd5, 1'b0, d);
        submit(3'd7, 3'd3, 1'b1, d);
        test_seal_output("backpressure");
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_id     = 3'd6;
            bus.in_bid    = 3'd4;
            bus.close     = 1'b1;
            bus.out_ready = 1'b0;
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.bid !== mdl_bid ||
                bus.bid_mask !== mdl_mask || bus.bid_count !== mdl_count) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: ov=%b ir=%b bid=%h mask=%b count=%0d required 1/0/%h/%b/%0d",
                         i, bus.out_valid, bus.in_ready, bus.bid, bus.bid_mask, bus.bid_count, mdl_bid, mdl_mask, mdl_count);
            end
        end
        idle_inputs();
        consume("backpressure");
    endtask

    task automatic test_out_ready_in_collect();
        logic d;
        bus.out_ready = 1'b1;
        submit(3'd5, 3'd2, 1'b0, d);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.bid_count !== 4'd1 || bus.bid[5*W +: W] !== 3'd2) begin
            n_fail++;
            $display("FAIL collect_out_ready: ov=%b count=%0d slot5=%0d required 0/1/2", bus.out_valid, bus.bid_count, bus.bid[5*W +: W]);
        end
        seal_close();
        test_seal_output("collect_out_ready");
        consume("collect_out_ready");
    endtask

    task automatic test_reset_mid();
        logic d;
        submit(3'd1, 3'd3, 1'b0, d);
        submit(3'd2, 3'd4, 1'b0, d);
        submit(3'd6, 3'd5, 1'b0, d);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_id    = 3'd0;
        bus.in_bid   = 3'd7;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        mdl_clear();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bid !== '0 ||
            bus.bid_mask !== '0 || bus.bid_count !== '0 || bus.dup_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: ir=%b ov=%b bid=%h mask=%b count=%0d dup=%b required 1/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.bid, bus.bid_mask, bus.bid_count, bus.dup_err);
        end
    endtask

    task automatic test_empty_close();
        do_reset();
        seal_close();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.bid !== '0 || bus.bid_mask !== '0 || bus.bid_count !== '0) begin
            n_fail++;
            $display("FAIL empty_close: ov=%b bid=%h mask=%b count=%0d required 1/0/0/0", bus.out_valid, bus.bid, bus.bid_mask, bus.bid_count);
        end
        test_seal_output("empty_close");
        consume("empty_close");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mdl_clear();
        test_reset();
        test_full_fill();
        test_duplicate();
        test_early_close();
        test_backpressure();
        test_out_ready_in_collect();
        test_reset_mid();
        test_empty_close();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected seals never observed, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end
endmodule
